// File: rtl/cnn_stream_pkg.sv
// cnn_stream_pkg: shared FSM state encoding and frame geometry helpers for the pixel stream blocks
package cnn_stream_pkg;
    typedef enum logic [2:0] {IDLE, READ, DRAIN, FLUSH, DONE} stream_state_t;
    localparam int ROW_SIZE_DEF = 28;
    localparam int COL_SIZE_DEF = 28;
    localparam int FRAME_PIXELS = ROW_SIZE_DEF * COL_SIZE_DEF;
    function automatic int frame_pixels(input int row_size, input int col_size);
        return row_size * col_size;
    endfunction
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-deep register FIFO with push/pop, occupancy count and head-of-queue view
module stream_fifo2 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    // storage, pointers and count; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/pixel_stream_source.sv
// pixel_stream_source: streams one BRAM frame in raster order with back-pressure and an optional zero flush
module pixel_stream_source
    import cnn_stream_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int ROW_SIZE     = 28,
    parameter int COL_SIZE     = 28,
    parameter int ADDR_WIDTH   = 10,
    parameter int FLUSH_PIXELS = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        out_ready,
    output logic                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [DATA_SIZE-1:0]        mem_rd_data,
    output logic                        data_valid,
    output logic [DATA_SIZE-1:0]        pixel_out,
    output logic [$clog2(COL_SIZE)-1:0] row_idx,
    output logic [$clog2(ROW_SIZE)-1:0] col_idx,
    output logic                        busy,
    output logic                        frame_done
);
    localparam int RW = $clog2(COL_SIZE);
    localparam int CW = $clog2(ROW_SIZE);
    localparam int FW = FLUSH_PIXELS > 0 ? $clog2(FLUSH_PIXELS + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(frame_pixels(ROW_SIZE, COL_SIZE) - 1);
    localparam logic [RW-1:0]         ROW_LAST   = RW'(COL_SIZE - 1);
    localparam logic [CW-1:0]         COL_LAST   = CW'(ROW_SIZE - 1);
    localparam logic [FW-1:0]         FLUSH_LAST = FW'(FLUSH_PIXELS - 1);

    stream_state_t          state, state_n;
    logic                   inflight;
    logic [FW-1:0]          flush_cnt;
    logic [1:0]             fifo_count;
    logic [DATA_SIZE-1:0]   fifo_head;
    logic [DATA_SIZE-1:0]   pixel_q;
    logic                   pop;
    logic                   drained;
    logic [2:0]             level;

    stream_fifo2 #(.W(DATA_SIZE)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   (mem_rd_data),
        .head  (fifo_head),
        .count (fifo_count)
    );

    // Reads are throttled so buffered plus in-flight pixels never exceed the two FIFO slots
    assign pop        = out_ready && fifo_count != 2'd0;
    assign data_valid = pop || (out_ready && state == FLUSH);
    assign level      = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign mem_rd_en  = state == READ && level < 3'd2;
    assign drained    = !inflight && fifo_count == {1'b0, pop};
    assign pixel_out  = pop ? fifo_head : (data_valid ? '0 : pixel_q);
    assign busy       = state != IDLE;
    assign frame_done = state == DONE;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // next-state: drain is judged after this cycle's pop so frame_done follows the last pixel directly
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = start ? READ : IDLE;
            READ:  state_n = (mem_rd_en && mem_addr == LAST_ADDR) ? DRAIN : READ;
            DRAIN: state_n = drained ? (FLUSH_PIXELS > 0 ? FLUSH : DONE) : DRAIN;
            FLUSH: state_n = (data_valid && flush_cnt == FLUSH_LAST) ? DONE : FLUSH;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // address, in-flight flag, flush count, held pixel and raster position of the next frame pixel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            inflight  <= 1'b0;
            flush_cnt <= '0;
            pixel_q   <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
        end else begin
            inflight <= mem_rd_en;
            if (state == DONE) mem_addr <= '0;
            else if (mem_rd_en) mem_addr <= mem_addr + 1'b1;
            if (state != FLUSH) flush_cnt <= '0;
            else if (data_valid) flush_cnt <= flush_cnt + 1'b1;
            if (data_valid) pixel_q <= pixel_out;
            if (pop) begin
                col_idx <= col_idx == COL_LAST ? '0 : col_idx + 1'b1;
                if (col_idx == COL_LAST) row_idx <= row_idx == ROW_LAST ? '0 : row_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_source.sv
// tb_pixel_stream_source: scoreboard bench for a 4x3 frame source, one instance plain and one with a 5-pixel flush
module tb_pixel_stream_source;
    logic       clock = 0;
    logic       reset;
    logic       out_ready;
    logic       start [2];
    logic       rd [2];
    logic [9:0] ad [2];
    logic [7:0] rdata [2];
    logic       dv [2];
    logic [7:0] px [2];
    logic [1:0] row [2];
    logic [1:0] col [2];
    logic       busy [2];
    logic       done [2];
    logic [7:0] mem [0:1023];

    int q0[$];
    int q1[$];
    int nvec = 0, nerr = 0, cyc = 0, s_cyc = 0, outst = 0;
    int ndv [2] = '{0, 0};
    int ndone [2] = '{0, 0};
    int nexta [2] = '{0, 0};
    int first_dv [2] = '{-1, -1};
    int last_dv [2] = '{0, 0};

    always #5 clock = ~clock;

    pixel_stream_source #(.DATA_SIZE(8), .ROW_SIZE(4), .COL_SIZE(3), .ADDR_WIDTH(10), .FLUSH_PIXELS(0)) u_dut (
        .clock(clock), .reset(reset), .start(start[0]), .out_ready(out_ready),
        .mem_rd_en(rd[0]), .mem_addr(ad[0]), .mem_rd_data(rdata[0]),
        .data_valid(dv[0]), .pixel_out(px[0]), .row_idx(row[0]), .col_idx(col[0]),
        .busy(busy[0]), .frame_done(done[0])
    );

    pixel_stream_source #(.DATA_SIZE(8), .ROW_SIZE(4), .COL_SIZE(3), .ADDR_WIDTH(10), .FLUSH_PIXELS(5)) u_dut_fl (
        .clock(clock), .reset(reset), .start(start[1]), .out_ready(out_ready),
        .mem_rd_en(rd[1]), .mem_addr(ad[1]), .mem_rd_data(rdata[1]),
        .data_valid(dv[1]), .pixel_out(px[1]), .row_idx(row[1]), .col_idx(col[1]),
        .busy(busy[1]), .frame_done(done[1])
    );

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) if (rd[d]) rdata[d] <= mem[ad[d]];
    end

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qsz(input int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction

    function automatic int qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // output monitor: scoreboard pops, frame_done timing, address order, read throttling
    always @(negedge clock) begin
        int got;
        if (reset) outst = 0;
        else begin
            for (int d = 0; d < 2; d++) begin
                if (dv[d]) begin
                    got = int'(px[d]) | (int'(row[d]) << 8) | (int'(col[d]) << 12);
                    if (qsz(d) == 0) check("extra_pixel", got, -1);
                    else check("pixel", got, qpop(d));
                    if (first_dv[d] < 0) first_dv[d] = cyc;
                    last_dv[d] = cyc;
                    ndv[d]++;
                end
                if (done[d]) begin
                    ndone[d]++;
                    check("done_timing", cyc, last_dv[d] + 1);
                    check("done_drained", qsz(d), 0);
                end
                if (rd[d]) begin
                    check("mem_addr", int'(ad[d]), nexta[d]);
                    nexta[d]++;
                end
            end
            if (rd[0]) check("no_overissue", int'((outst - int'(dv[0])) < 2), 1);
            outst = outst + int'(rd[0]) - int'(dv[0]);
        end
    end

    task automatic start_frame(input int d);
        for (int i = 0; i < 12; i++) begin
            if (d == 0) q0.push_back(i | ((i / 4) << 8) | ((i % 4) << 12));
            else q1.push_back(i | ((i / 4) << 8) | ((i % 4) << 12));
        end
        if (d == 1) for (int i = 0; i < 5; i++) q1.push_back(0);
        nexta[d] = 0;
        first_dv[d] = -1;
        start[d] = 1;
        @(posedge clock); #1;
        start[d] = 0;
        s_cyc = cyc;
    endtask

    task automatic run_to_done(input int d, input bit pat);
        int n0;
        bit ok;
        n0 = ndone[d];
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (pat) out_ready = (k % 4 == 0) || (k % 4 == 3);
            if (ndone[d] != n0) begin
                ok = 1;
                break;
            end
            check("busy_in_frame", int'(busy[d]), 1);
            @(posedge clock); #1;
        end
        out_ready = 1;
        check("frame_done_seen", int'(ok), 1);
        check("done_count", ndone[d] - n0, 1);
        check("busy_after", int'(busy[d]), 0);
    endtask

    task automatic wait_pixel(input int v);
        bit seen;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (dv[0] && px[0] == 8'(v)) begin
                seen = 1;
                break;
            end
            @(posedge clock); #1;
        end
        check("pixel_reached", int'(seen), 1);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        reset = 1;
        out_ready = 0;
        start[0] = 0;
        start[1] = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_dv", int'(dv[0]), 0);
        check("reset_busy", int'(busy[0]), 0);
        check("reset_rd", int'(rd[0]), 0);
        check("reset_pixel", int'(px[0]), 0);
        check("reset_rowcol", int'({row[0], col[0]}), 0);
        check("reset_done", int'(done[0]), 0);
        @(posedge clock); #1;
        reset = 0;
        out_ready = 1;
        @(posedge clock); #1;

        // 1: full-rate frame
        start_frame(0);
        run_to_done(0, 0);
        check("first_latency", first_dv[0], s_cyc + 2);
        check("consecutive", last_dv[0] - first_dv[0], 11);
        check("pixel_hold", int'(px[0]), 11);
        check("idle_rowcol", int'({row[0], col[0]}), 0);
        repeat (2) @(posedge clock);
        #1;

        // 2: back-pressure 1,0,0,1
        start_frame(0);
        run_to_done(0, 1);
        repeat (2) @(posedge clock);
        #1;

        // 3: flush of five zeros
        start_frame(1);
        run_to_done(1, 0);
        check("flush_pixel_zero", int'(px[1]), 0);
        repeat (2) @(posedge clock);
        #1;

        // 4: start during the frame is ignored
        start_frame(0);
        wait_pixel(6);
        start[0] = 1;
        @(posedge clock); #1;
        start[0] = 0;
        n0 = ndone[0];
        run_to_done(0, 0);
        repeat (5) @(posedge clock);
        #1;
        check("single_done", ndone[0] - n0, 1);
        check("idle_no_read", int'(rd[0]), 0);

        // 5: reset mid-frame
        start_frame(0);
        wait_pixel(7);
        n0 = ndone[0];
        @(posedge clock); #1;
        reset = 1;
        #1;
        check("abort_dv", int'(dv[0]), 0);
        check("abort_busy", int'(busy[0]), 0);
        check("abort_pixel", int'(px[0]), 0);
        check("abort_rowcol", int'({row[0], col[0]}), 0);
        check("abort_rd", int'(rd[0]), 0);
        q0.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        @(posedge clock); #1;
        check("abort_no_done", ndone[0] - n0, 0);
        start_frame(0);
        run_to_done(0, 0);

        // 6: back-to-back frame started the cycle after frame_done
        start_frame(0);
        run_to_done(0, 0);
        check("b2b_drained", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
